// File: rtl/face_bbox_pkg.sv
// Shared definitions for the skin-mask pipeline: frame geometry defaults and
// the frame-tracking FSM encoding used by the bounding-box stage.
package face_bbox_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_X_W        = 10;
    localparam int DEF_Y_W        = 10;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } bbox_state_t;

endpackage : face_bbox_pkg

// File: rtl/face_bbox_raster_counter.sv
// Raster-order column/row counter. 'clear' restarts at (0,0) and 'step'
// advances one pixel from the restarted or current position.
module raster_counter
    import face_bbox_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W
) (
    input  logic           sclk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic           last_pixel
);

    localparam logic [X_W-1:0] COL_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0] col_base, col_next;
    logic [Y_W-1:0] row_base, row_next;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        col_base = clear ? '0 : col;
        row_base = clear ? '0 : row;
        col_next = col_base;
        row_next = row_base;
        if (step) begin
            if (col_base == COL_LAST) begin
                col_next = '0;
                row_next = (row_base == ROW_LAST) ? '0 : row_base + Y_W'(1);
            end else begin
                col_next = col_base + X_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of block ordering.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_next;
            row <= row_next;
        end
    end

    assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

endmodule : raster_counter

// File: rtl/face_bbox.sv
// Per-frame bounding box and pixel count of the binary skin mask; posts one
// result with a box_valid pulse after the last pixel of each complete frame.
module face_bbox
    import face_bbox_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int CNT_W      = 19,
    parameter int MIN_PIXELS = 256
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [7:0]       face_data,
    input  logic             face_flag,
    output logic [X_W-1:0]   box_x_min,
    output logic [X_W-1:0]   box_x_max,
    output logic [Y_W-1:0]   box_y_min,
    output logic [Y_W-1:0]   box_y_max,
    output logic [CNT_W-1:0] skin_count,
    output logic             box_found,
    output logic             box_valid,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

    bbox_state_t state, state_next;

    logic [X_W-1:0]   col, pix_col;
    logic [Y_W-1:0]   row, pix_row;
    logic             last_pixel;
    logic             pix_valid, fin, fresh, rc_step, skin;

    logic [X_W-1:0]   x_min_q, x_max_q, x_min_d, x_max_d;
    logic [Y_W-1:0]   y_min_q, y_max_q, y_min_d, y_max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    raster_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_raster (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .step      (rc_step),
        .col       (col),
        .row       (row),
        .last_pixel(last_pixel)
    );

    // A frame_start landing on the last pixel leaves that pixel in the old
    // frame; otherwise the flagged pixel becomes (0,0) of the new one.
    always_comb begin
        pix_valid = face_flag && ((state == ACTIVE) || frame_start);
        fin       = (state == ACTIVE) && face_flag && last_pixel;
        fresh     = frame_start && !fin;
        rc_step   = pix_valid && !(fin && frame_start);
        skin      = (face_data != 8'd0);
        pix_col   = fresh ? '0 : col;
        pix_row   = fresh ? '0 : row;

        x_min_d = fresh ? '1 : x_min_q;
        x_max_d = fresh ? '0 : x_max_q;
        y_min_d = fresh ? '1 : y_min_q;
        y_max_d = fresh ? '0 : y_max_q;
        cnt_d   = fresh ? '0 : cnt_q;

        if (pix_valid && skin) begin
            if (pix_col < x_min_d) x_min_d = pix_col;
            if (pix_col > x_max_d) x_max_d = pix_col;
            if (pix_row < y_min_d) y_min_d = pix_row;
            if (pix_row > y_max_d) y_max_d = pix_row;
            if (cnt_d != CNT_MAX)  cnt_d   = cnt_d + CNT_W'(1);
        end

        state_next = state;
        if (frame_start)
            state_next = ACTIVE;
        else if (fin)
            state_next = WAIT_SOF;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_SOF;
            x_min_q <= '1;
            x_max_q <= '0;
            y_min_q <= '1;
            y_max_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_next;
            if (fin) begin
                x_min_q <= '1;
                x_max_q <= '0;
                y_min_q <= '1;
                y_max_q <= '0;
                cnt_q   <= '0;
            end else begin
                x_min_q <= x_min_d;
                x_max_q <= x_max_d;
                y_min_q <= y_min_d;
                y_max_q <= y_max_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    // Sentinel extremes are replaced by zeros when the frame held no skin.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            skin_count <= '0;
            box_found  <= 1'b0;
            box_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            box_valid <= fin;
            frame_err <= (state == ACTIVE) && frame_start && !fin;
            if (fin) begin
                if (cnt_d == '0) begin
                    box_x_min <= '0;
                    box_x_max <= '0;
                    box_y_min <= '0;
                    box_y_max <= '0;
                end else begin
                    box_x_min <= x_min_d;
                    box_x_max <= x_max_d;
                    box_y_min <= y_min_d;
                    box_y_max <= y_max_d;
                end
                skin_count <= cnt_d;
                box_found  <= (cnt_d >= CNT_MIN);
            end
        end
    end

endmodule : face_bbox

// File: tb/tb_face_bbox.sv
// Self-checking bench for face_bbox on an 8x6 frame: a frame-level model
// predicts each result and a per-cycle compare process checks the DUT.
module tb_face_bbox;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int X_W   = 4;
    localparam int Y_W   = 4;
    localparam int CNT_W = 8;
    localparam int MINP  = 4;

    typedef struct {
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        int found;
    } res_t;

    logic             sclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic [7:0]       face_data = 8'd0;
    logic             face_flag = 1'b0;
    logic [X_W-1:0]   box_x_min, box_x_max;
    logic [Y_W-1:0]   box_y_min, box_y_max;
    logic [CNT_W-1:0] skin_count;
    logic             box_found, box_valid, frame_err;

    face_bbox #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .CNT_W     (CNT_W),
        .MIN_PIXELS(MINP)
    ) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .face_data  (face_data),
        .face_flag  (face_flag),
        .box_x_min  (box_x_min),
        .box_x_max  (box_x_max),
        .box_y_min  (box_y_min),
        .box_y_max  (box_y_max),
        .skin_count (skin_count),
        .box_found  (box_found),
        .box_valid  (box_valid),
        .frame_err  (frame_err)
    );

    always #5 sclk = ~sclk;

    logic [7:0] mask [0:H-1][0:W-1];
    res_t pend_res;
    res_t held;
    int   pend_due = -1;
    int   err_due  = -1;
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;
    bit   run      = 1'b0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t zero_res();
        res_t r;
        r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0; r.cnt = 0; r.found = 0;
        return r;
    endfunction

    // Frame-level reference: scan the whole mask and take extremes and count.
    function automatic res_t model();
        res_t r;
        r = zero_res();
        r.xmin = W; r.ymin = H;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (mask[y][x] != 8'd0) begin
                    r.cnt++;
                    if (x < r.xmin) r.xmin = x;
                    if (x > r.xmax) r.xmax = x;
                    if (y < r.ymin) r.ymin = y;
                    if (y > r.ymax) r.ymax = y;
                end
        if (r.cnt == 0) r = zero_res();
        r.found = (r.cnt >= MINP) ? 1 : 0;
        return r;
    endfunction

    // Per-cycle compare: pulses must appear exactly when due, results hold otherwise.
    always @(negedge sclk) begin
        if (run) begin
            bit ev, ee;
            ev = (pend_due == cyc);
            ee = (err_due == cyc);
            if (!rst_n) held = zero_res();
            else if (ev) held = pend_res;
            check("box_valid",  int'(box_valid),  int'(ev && rst_n));
            check("frame_err",  int'(frame_err),  int'(ee && rst_n));
            check("box_x_min",  int'(box_x_min),  held.xmin);
            check("box_x_max",  int'(box_x_max),  held.xmax);
            check("box_y_min",  int'(box_y_min),  held.ymin);
            check("box_y_max",  int'(box_y_max),  held.ymax);
            check("skin_count", int'(skin_count), held.cnt);
            check("box_found",  int'(box_found),  held.found);
        end
    end

    task automatic drive(input bit fs, input bit flag, input logic [7:0] d);
        frame_start = fs;
        face_flag   = flag;
        face_data   = d;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_mask();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mask[y][x] = 8'd0;
    endtask

    // mode 0: separate frame_start cycle, 1: frame_start with first pixel,
    // 2: frame already started by a previous frame_start.
    task automatic send_frame(input int mode, input int gap_pct, input bit fs_last);
        if (mode == 0) drive(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                bit first, last;
                first = (y == 0) && (x == 0);
                last  = (y == H - 1) && (x == W - 1);
                if (!(first && mode == 1)) begin
                    int g;
                    g = 0;
                    while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
                        drive(1'b0, 1'b0, 8'hFF);
                        g++;
                    end
                end
                if (last) begin
                    pend_res = model();
                    pend_due = cyc + 1;
                end
                drive((first && mode == 1) || (last && fs_last), 1'b1, mask[y][x]);
            end
    endtask

    task automatic lit(input string tag, input int xmin, input int xmax, input int ymin,
                       input int ymax, input int cnt, input int found);
        check({tag, ".x_min"}, int'(box_x_min),  xmin);
        check({tag, ".x_max"}, int'(box_x_max),  xmax);
        check({tag, ".y_min"}, int'(box_y_min),  ymin);
        check({tag, ".y_max"}, int'(box_y_max),  ymax);
        check({tag, ".count"}, int'(skin_count), cnt);
        check({tag, ".found"}, int'(box_found),  found);
    endtask

    task automatic set_three();
        clear_mask();
        mask[1][2] = 8'hFF;
        mask[1][5] = 8'hFF;
        mask[4][3] = 8'hFF;
    endtask

    task automatic set_block();
        clear_mask();
        for (int y = 2; y <= 4; y++)
            for (int x = 4; x <= 5; x++)
                mask[y][x] = 8'hFF;
    endtask

    initial begin
        clear_mask();
        repeat (3) @(posedge sclk);
        #1;
        lit("reset", 0, 0, 0, 0, 0, 0);
        check("reset.box_valid", int'(box_valid), 0);
        rst_n = 1'b1;
        run   = 1'b1;
        idle(2);

        // Three scattered skin pixels, gapless, then stray pixels after completion.
        set_three();
        send_frame(0, 0, 1'b0);
        idle(2);
        lit("three", 2, 5, 1, 4, 3, 0);
        repeat (5) drive(1'b0, 1'b1, 8'hFF);
        idle(2);

        // 2x3 block, frame_start coinciding with the first pixel.
        set_block();
        send_frame(1, 0, 1'b0);
        idle(2);
        lit("block", 4, 5, 2, 4, 6, 1);

        // Empty frame.
        clear_mask();
        send_frame(0, 0, 1'b0);
        idle(2);
        lit("empty", 0, 0, 0, 0, 0, 0);

        // Opposite corners, including (0,0) on the frame_start cycle.
        clear_mask();
        mask[0][0] = 8'h01;
        mask[H-1][W-1] = 8'h80;
        send_frame(1, 0, 1'b0);
        idle(2);
        lit("corners", 0, 7, 0, 5, 2, 0);

        // Frame aborted after 20 pixels; its skin must not leak into the next.
        clear_mask();
        mask[0][0] = 8'hFF;
        mask[1][3] = 8'hFF;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, mask[i / W][i % W]);
        err_due = cyc + 1;
        drive(1'b1, 1'b0, 8'h00);
        set_block();
        send_frame(2, 0, 1'b0);
        idle(2);
        lit("abort", 4, 5, 2, 4, 6, 1);

        // Gapped frame whose last pixel carries the next frame_start.
        set_three();
        send_frame(0, 30, 1'b1);
        set_block();
        send_frame(2, 0, 1'b0);
        idle(2);
        lit("chain", 4, 5, 2, 4, 6, 1);

        // Reset mid-frame, then pixels without frame_start are ignored.
        drive(1'b1, 1'b0, 8'h00);
        repeat (10) drive(1'b0, 1'b1, 8'hFF);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        repeat (W * H) drive(1'b0, 1'b1, 8'hFF);
        idle(3);
        lit("rst_mid", 0, 0, 0, 0, 0, 0);
        check("all_results_seen", int'(pend_due < cyc), 1);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_face_bbox
